seq_trig_gen: RTL and testbench

SEQ_TRIG_GEN -- requirements
Module: seq_trig_gen

---
 rtl/seq_trig_pkg.sv | 16 +
 rtl/seq_trig_match.sv | 38 +++
 rtl/seq_trig_gen.sv | 133 +++++++++++++
 tb/tb_seq_trig_gen.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_trig_pkg.sv
// Shared definitions for the sequence trigger generator: FSM state encoding
// and default widths of the match path and the run counters.
package seq_trig_pkg;

    localparam int unsigned IN_BITS_DEF  = 8;
    localparam int unsigned CNT_BITS_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_MATCH = 3'd1,
        ST_DELAY      = 3'd2,
        ST_FIRE       = 3'd3,
        ST_HOLDOFF    = 3'd4
    } state_t;

endpackage

// File: rtl/seq_trig_match.sv
// Registers the monitored sequence input, applies the masked pattern compare
// and, in edge mode, qualifies only false-to-true transitions of the match.
module seq_trig_match
    import seq_trig_pkg::*;
#(
    parameter int unsigned IN_BITS = IN_BITS_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [IN_BITS-1:0] seq_in,
    input  logic [IN_BITS-1:0] pattern_cfg,
    input  logic [IN_BITS-1:0] mask_cfg,
    input  logic               edge_mode_cfg,
    input  logic               arm_load,
    output logic               qual_match
);

    logic [IN_BITS-1:0] seq_in_q;
    logic               match;
    logic               prev_match;

    assign match = (((seq_in_q ^ pattern_cfg) & mask_cfg) == '0);

    // Forcing the history flag on arm keeps a pattern already present at arm
    // time from counting as a fresh edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq_in_q   <= '0;
            prev_match <= 1'b0;
        end else begin
            seq_in_q   <= seq_in;
            prev_match <= arm_load ? 1'b1 : match;
        end
    end

    assign qual_match = edge_mode_cfg ? (match && !prev_match) : match;

endmodule

// File: rtl/seq_trig_gen.sv
// Armed pattern trigger: on a qualifying SEQ_IN match waits DELAY cycles, issues a
// one-cycle SEQ_EXT_START, then holds off and repeats. SEQ_TRIG_TIMESTAMP_EN adds TS_LAST.
module seq_trig_gen
    import seq_trig_pkg::*;
#(
    parameter int unsigned IN_BITS  = IN_BITS_DEF,
    parameter int unsigned CNT_BITS = CNT_BITS_DEF
) (
    input  logic                SEQ_CLK,
    input  logic                SEQ_RST,
    input  logic [IN_BITS-1:0]  SEQ_IN,
    input  logic                ARM,
    input  logic                DISARM,
    input  logic [IN_BITS-1:0]  PATTERN,
    input  logic [IN_BITS-1:0]  MASK,
    input  logic                EDGE_MODE,
    input  logic [CNT_BITS-1:0] DELAY,
    input  logic [CNT_BITS-1:0] HOLDOFF,
    input  logic [CNT_BITS-1:0] REPEAT,
    output logic                SEQ_EXT_START,
    output logic                BUSY,
    output logic [CNT_BITS-1:0] TRIG_CNT
`ifdef SEQ_TRIG_TIMESTAMP_EN
    ,
    output logic [31:0]         TS_LAST
`endif
);

    state_t state, state_nxt;

    logic [IN_BITS-1:0]  pattern_cfg, mask_cfg;
    logic                edge_mode_cfg;
    logic [CNT_BITS-1:0] delay_cfg, holdoff_cfg, repeat_cfg;
    logic [CNT_BITS-1:0] cnt;
    logic [CNT_BITS-1:0] trig_cnt_inc;
    logic                qual_match;
    logic                arm_ok;
    logic                fire_ok;

    assign arm_ok       = ARM && !DISARM && (state == ST_IDLE);
    assign fire_ok      = (state == ST_FIRE) && !DISARM;
    assign trig_cnt_inc = (TRIG_CNT == '1) ? TRIG_CNT : TRIG_CNT + 1'b1;

    seq_trig_match #(
        .IN_BITS (IN_BITS)
    ) u_match (
        .clk           (SEQ_CLK),
        .rst           (SEQ_RST),
        .seq_in        (SEQ_IN),
        .pattern_cfg   (pattern_cfg),
        .mask_cfg      (mask_cfg),
        .edge_mode_cfg (edge_mode_cfg),
        .arm_load      (arm_ok),
        .qual_match    (qual_match)
    );

    always_ff @(posedge SEQ_CLK or posedge SEQ_RST) begin
        if (SEQ_RST) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:       if (arm_ok) state_nxt = ST_WAIT_MATCH;
            ST_WAIT_MATCH: if (qual_match)
                               state_nxt = (delay_cfg == '0) ? ST_FIRE : ST_DELAY;
            ST_DELAY:      if (cnt <= CNT_BITS'(1)) state_nxt = ST_FIRE;
            ST_FIRE: begin
                if ((repeat_cfg != '0) && (trig_cnt_inc == repeat_cfg))
                    state_nxt = ST_IDLE;
                else if (holdoff_cfg == '0)
                    state_nxt = ST_WAIT_MATCH;
                else
                    state_nxt = ST_HOLDOFF;
            end
            ST_HOLDOFF:    if (cnt <= CNT_BITS'(1)) state_nxt = ST_WAIT_MATCH;
            default:       state_nxt = ST_IDLE;
        endcase
        if (DISARM) state_nxt = ST_IDLE;
    end

    // The pulse is gated by DISARM so an abort landing on the FIRE cycle issues nothing.
    always_comb begin
        SEQ_EXT_START = fire_ok;
        BUSY          = (state != ST_IDLE);
    end

    always_ff @(posedge SEQ_CLK or posedge SEQ_RST) begin
        if (SEQ_RST) begin
            pattern_cfg   <= '0;
            mask_cfg      <= '0;
            edge_mode_cfg <= 1'b0;
            delay_cfg     <= '0;
            holdoff_cfg   <= '0;
            repeat_cfg    <= '0;
            cnt           <= '0;
            TRIG_CNT      <= '0;
        end else begin
            if (arm_ok) begin
                pattern_cfg   <= PATTERN;
                mask_cfg      <= MASK;
                edge_mode_cfg <= EDGE_MODE;
                delay_cfg     <= DELAY;
                holdoff_cfg   <= HOLDOFF;
                repeat_cfg    <= REPEAT;
                TRIG_CNT      <= '0;
            end
            if (fire_ok) TRIG_CNT <= trig_cnt_inc;
            unique case (state)
                ST_WAIT_MATCH:       if (qual_match) cnt <= delay_cfg;
                ST_FIRE:             cnt <= holdoff_cfg;
                ST_DELAY, ST_HOLDOFF: cnt <= cnt - 1'b1;
                default:             cnt <= cnt;
            endcase
        end
    end

`ifdef SEQ_TRIG_TIMESTAMP_EN
    logic [31:0] ts_cnt;

    always_ff @(posedge SEQ_CLK or posedge SEQ_RST) begin
        if (SEQ_RST) begin
            ts_cnt  <= '0;
            TS_LAST <= '0;
        end else begin
            ts_cnt <= ts_cnt + 1'b1;
            if (fire_ok) TS_LAST <= ts_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_seq_trig_gen.sv
// Directed bench for seq_trig_gen: latency, masking, repeat/holdoff, edge mode,
// disarm and reset behaviour. Builds with or without SEQ_TRIG_TIMESTAMP_EN.
module tb_seq_trig_gen;

    logic        SEQ_CLK = 1'b0;
    logic        SEQ_RST = 1'b1;
    logic [7:0]  SEQ_IN = '0;
    logic        ARM = 1'b0;
    logic        DISARM = 1'b0;
    logic [7:0]  PATTERN = '0;
    logic [7:0]  MASK = '0;
    logic        EDGE_MODE = 1'b0;
    logic [15:0] DELAY = '0;
    logic [15:0] HOLDOFF = '0;
    logic [15:0] REPEAT = '0;
    logic        SEQ_EXT_START;
    logic        BUSY;
    logic [15:0] TRIG_CNT;
`ifdef SEQ_TRIG_TIMESTAMP_EN
    logic [31:0] TS_LAST;
    logic [31:0] cyc = '0;
    logic [31:0] ts_exp;

    always @(posedge SEQ_CLK or posedge SEQ_RST) begin
        if (SEQ_RST) cyc <= '0;
        else         cyc <= cyc + 1;
    end
`endif

    int checks = 0;
    int errors = 0;
    int n;

    seq_trig_gen #(
        .IN_BITS  (8),
        .CNT_BITS (16)
    ) dut (
        .SEQ_CLK       (SEQ_CLK),
        .SEQ_RST       (SEQ_RST),
        .SEQ_IN        (SEQ_IN),
        .ARM           (ARM),
        .DISARM        (DISARM),
        .PATTERN       (PATTERN),
        .MASK          (MASK),
        .EDGE_MODE     (EDGE_MODE),
        .DELAY         (DELAY),
        .HOLDOFF       (HOLDOFF),
        .REPEAT        (REPEAT),
        .SEQ_EXT_START (SEQ_EXT_START),
        .BUSY          (BUSY),
        .TRIG_CNT      (TRIG_CNT)
`ifdef SEQ_TRIG_TIMESTAMP_EN
        ,
        .TS_LAST       (TS_LAST)
`endif
    );

    always #5 SEQ_CLK = ~SEQ_CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge SEQ_CLK);
        #1;
    endtask

    // Steps until a start pulse is seen; returns the step count, or -1 past the bound.
    task automatic wait_pulse(input int max, output int cnt);
        cnt = -1;
        for (int i = 1; i <= max; i++) begin
            step();
            if (SEQ_EXT_START) begin
                cnt = i;
                break;
            end
        end
    endtask

    task automatic count_pulses(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (SEQ_EXT_START) pulses++;
        end
    endtask

    task automatic setup(input logic [7:0] pat, input logic [7:0] msk, input logic edg,
                         input logic [15:0] dly, input logic [15:0] hld, input logic [15:0] rep);
        PATTERN   = pat;
        MASK      = msk;
        EDGE_MODE = edg;
        DELAY     = dly;
        HOLDOFF   = hld;
        REPEAT    = rep;
    endtask

    task automatic arm();
        ARM = 1'b1;
        step();
        ARM = 1'b0;
    endtask

    initial begin
        // Reset state
        #1;
        check("rst_start", {31'd0, SEQ_EXT_START}, 32'd0);
        check("rst_busy", {31'd0, BUSY}, 32'd0);
        check("rst_cnt", {16'd0, TRIG_CNT}, 32'd0);
`ifdef SEQ_TRIG_TIMESTAMP_EN
        check("rst_ts", TS_LAST, 32'd0);
`endif
        step();
        step();
        SEQ_RST = 1'b0;

        // Exact match, no delay, single shot
        setup(8'hA5, 8'hFF, 1'b0, 16'd0, 16'd0, 16'd1);
        SEQ_IN = 8'h00;
        arm();
        check("arm_busy", {31'd0, BUSY}, 32'd1);
        check("arm_cnt_clr", {16'd0, TRIG_CNT}, 32'd0);
        count_pulses(3, n);
        check("no_match_quiet", n, 32'd0);
        SEQ_IN = 8'hA5;
        wait_pulse(10, n);
        check("lat_d0", n, 32'd2);
        check("cnt_in_fire", {16'd0, TRIG_CNT}, 32'd0);
        step();
        check("pulse_1cyc", {31'd0, SEQ_EXT_START}, 32'd0);
        check("single_cnt", {16'd0, TRIG_CNT}, 32'd1);
        check("single_idle", {31'd0, BUSY}, 32'd0);

        // Masked compare with delay; port changes after arm must be ignored
        SEQ_IN = 8'h30;
        setup(8'h05, 8'h0F, 1'b0, 16'd5, 16'd0, 16'd1);
        arm();
        PATTERN = 8'h0A;
        MASK    = 8'hFF;
        SEQ_IN  = 8'h35;
        wait_pulse(20, n);
        check("lat_d5_masked", n, 32'd7);
        step();
        check("d5_cnt", {16'd0, TRIG_CNT}, 32'd1);
        check("d5_idle", {31'd0, BUSY}, 32'd0);

        // Repeat 3 with holdoff 4
        SEQ_IN = 8'hA5;
        setup(8'hA5, 8'hFF, 1'b0, 16'd0, 16'd4, 16'd3);
        arm();
        wait_pulse(20, n);
        check("rep_first", n, 32'd1);
        wait_pulse(20, n);
        check("rep_space2", n, 32'd6);
        wait_pulse(20, n);
        check("rep_space3", n, 32'd6);
        check("rep_cnt_fire3", {16'd0, TRIG_CNT}, 32'd2);
        step();
        check("rep_cnt", {16'd0, TRIG_CNT}, 32'd3);
        check("rep_idle", {31'd0, BUSY}, 32'd0);
        count_pulses(10, n);
        check("rep_done_quiet", n, 32'd0);
        ARM = 1'b1;
        DISARM = 1'b1;
        step();
        ARM = 1'b0;
        DISARM = 1'b0;
        check("arm_disarm_idle", {31'd0, BUSY}, 32'd0);
        check("arm_disarm_cnt", {16'd0, TRIG_CNT}, 32'd3);

        // Edge mode: pattern present at arm does not fire
        setup(8'hA5, 8'hFF, 1'b1, 16'd0, 16'd0, 16'd1);
        arm();
        count_pulses(6, n);
        check("edge_armed_quiet", n, 32'd0);
        check("edge_busy", {31'd0, BUSY}, 32'd1);
        SEQ_IN = 8'h00;
        step();
        step();
        SEQ_IN = 8'hA5;
        wait_pulse(10, n);
        check("edge_fire", n, 32'd2);
        step();
        check("edge_cnt", {16'd0, TRIG_CNT}, 32'd1);

        // Zero mask matches anything
        SEQ_IN = 8'h00;
        setup(8'hFF, 8'h00, 1'b0, 16'd0, 16'd0, 16'd1);
        arm();
        wait_pulse(10, n);
        check("mask0_fire", n, 32'd1);
        step();

        // Disarm while in DELAY
        setup(8'h00, 8'hFF, 1'b0, 16'd5, 16'd0, 16'd0);
        arm();
        step();
        step();
        DISARM = 1'b1;
        step();
        DISARM = 1'b0;
        check("dis_delay_idle", {31'd0, BUSY}, 32'd0);
        check("dis_delay_nopulse", {31'd0, SEQ_EXT_START}, 32'd0);
        check("dis_delay_cnt", {16'd0, TRIG_CNT}, 32'd0);
        count_pulses(10, n);
        check("dis_delay_quiet", n, 32'd0);

        // Disarm on a FIRE cycle: no pulse, count held
        setup(8'h00, 8'hFF, 1'b0, 16'd0, 16'd0, 16'd0);
        arm();
        wait_pulse(10, n);
        check("unl_first", n, 32'd1);
        step();
        step();
        check("unl_second", {31'd0, SEQ_EXT_START}, 32'd1);
        DISARM = 1'b1;
        #1;
        check("dis_fire_gated", {31'd0, SEQ_EXT_START}, 32'd0);
        step();
        DISARM = 1'b0;
        check("dis_fire_idle", {31'd0, BUSY}, 32'd0);
        check("dis_fire_cnt", {16'd0, TRIG_CNT}, 32'd1);

        // Reset during FIRE
        arm();
        wait_pulse(10, n);
        check("rst_run_first", n, 32'd1);
`ifdef SEQ_TRIG_TIMESTAMP_EN
        ts_exp = cyc;
`endif
        step();
`ifdef SEQ_TRIG_TIMESTAMP_EN
        check("ts_at_fire", TS_LAST, ts_exp);
`endif
        step();
        check("rst_run_second", {31'd0, SEQ_EXT_START}, 32'd1);
        SEQ_RST = 1'b1;
        #1;
        check("rst_fire_start", {31'd0, SEQ_EXT_START}, 32'd0);
        check("rst_fire_cnt", {16'd0, TRIG_CNT}, 32'd0);
        check("rst_fire_busy", {31'd0, BUSY}, 32'd0);
`ifdef SEQ_TRIG_TIMESTAMP_EN
        check("rst_fire_ts", TS_LAST, 32'd0);
`endif
        step();
        SEQ_RST = 1'b0;
        count_pulses(10, n);
        check("post_rst_quiet", n, 32'd0);
        check("post_rst_idle", {31'd0, BUSY}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
